// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - load/store initiator for the 2048-word synchronous data memory
// Optional build macro ALIGN_CHECK_EN: reject misaligned half/word accesses instead of truncating the offset.
module data_mem_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                wr_q, uns_q, err_q;
  logic [1:0]          size_q, off_q;
  logic [31:0]         wdata_q, rdata_q;
  logic [ADDR_W-1:0]   idx_q;

  logic                accept, in_range, misalign, req_err;
  logic [31:0]         rel;
  logic [1:0]          req_off;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         load_ext;

  assign accept = req_valid && (state == IDLE);
  assign rel    = req_addr - BASE_ADDR;
  // Anything below the base wraps to a huge offset, so the upper-bits test also covers it.
  assign in_range = (req_addr >= BASE_ADDR) && ((rel >> (ADDR_W + 2)) == 32'd0);

`ifdef ALIGN_CHECK_EN
  assign misalign = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
  assign req_off  = req_addr[1:0];
`else
  assign misalign = 1'b0;
  always_comb begin
    case (req_size)
      2'd0:    req_off = req_addr[1:0];
      2'd1:    req_off = {req_addr[1], 1'b0};
      default: req_off = 2'd0;
    endcase
  end
`endif

  assign req_err = !in_range || (req_size == 2'd3) || misalign;

  // Big-endian lane selection: offset 0 is bits 31:24.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'd0:    load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      2'd1:    load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ISSUE;
      ISSUE:   state_nxt = wr_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      idx_q   <= '0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      wr_q    <= req_write;
      uns_q   <= req_unsigned;
      err_q   <= req_err;
      size_q  <= req_size;
      off_q   <= req_off;
      wdata_q <= req_wdata;
      idx_q   <= rel[ADDR_W+1:2];
      rdata_q <= 32'd0;
    end else if (state == WAIT) begin
      rdata_q <= load_ext;
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state)
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = idx_q;
        if (wr_q) begin
          case (size_q)
            2'd0: begin
              mem_we    = 4'b0001 << off_q;
              mem_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
              mem_we    = off_q[1] ? 4'b1100 : 4'b0011;
              mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
              mem_we    = 4'b1111;
              mem_wdata = wdata_q;
            end
          endcase
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - directed bench with byte-level reference model for data_mem_master
// Build with or without ALIGN_CHECK_EN; the reference model follows the same macro.
module tb_data_mem_master;

  localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_en;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;

  data_mem_master #(.BASE_ADDR(BASE), .ADDR_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Word-wide memory seen by the DUT, one-cycle registered read.
  logic [31:0] dmem [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) dmem[mem_addr][31-8*i -: 8] <= mem_wdata[31-8*i -: 8];
      mem_rdata <= dmem[mem_addr];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Reference model: byte-addressed big-endian image of the memory.
  logic [7:0]  gm [0:8191];
  logic        m_err;
  logic [31:0] m_rd, m_wd;
  logic [3:0]  m_we;
  logic [10:0] m_addr;

  task automatic model(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rel, eff, v;
    int n;
    rel   = a - BASE;
    m_err = (a < BASE) || (rel >= 32'd8192) || (sz == 2'd3) ||
            (ALIGN && (((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0))));
    m_rd = 32'd0; m_wd = 32'd0; m_we = 4'd0; m_addr = 11'd0;
    if (m_err) return;
    n      = 1 << sz;
    eff    = rel & ~(32'(n) - 32'd1);
    m_addr = eff[12:2];
    if (w) begin
      for (int k = 0; k < n; k++) begin
        gm[int'(eff) + k] = wd[8*(n-1-k) +: 8];
        m_we[(int'(eff) + k) % 4] = 1'b1;
      end
      m_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = (v << 8) | 32'(gm[int'(eff) + k]);
      if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      m_rd = v;
    end
  endtask

  typedef struct { int c; logic [10:0] addr; logic [3:0] we; logic [31:0] wd; } issue_t;
  typedef struct { int c; logic err; logic [31:0] d; } resp_t;
  issue_t iq[$];
  resp_t  rq[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (iq.size() > 0 && iq[0].c == cyc) begin
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("mem_addr", 32'(mem_addr), 32'(iq[0].addr));
        chk("mem_we", 32'(mem_we), 32'(iq[0].we));
        chk("mem_wdata", mem_wdata, iq[0].wd);
        void'(iq.pop_front());
      end else begin
        chk("mem_idle", {mem_wdata[30:0] != 31'd0 || mem_wdata[31], 21'd0, mem_addr, mem_we, mem_en}, 32'd0);
      end
      if (rq.size() > 0 && rq[0].c == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(rq[0].err));
        chk("rsp_rdata", rsp_rdata, rq[0].d);
        void'(rq.pop_front());
      end else begin
        chk("rsp_quiet", 32'(rsp_valid), 32'd0);
      end
    end
  end

  task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd);
    int A, lat;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    model(w, sz, u, a, wd);
    A   = cyc + 1;
    lat = m_err ? 0 : (w ? 1 : 2);
    if (!m_err) iq.push_back('{A, m_addr, m_we, m_wd});
    rq.push_back('{A + lat, m_err, m_rd});
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = BASE + ($urandom & 32'h1FFC); req_wdata = $urandom;
    repeat (lat + 1) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 8192; i++) gm[i] = 8'd0;
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_req(1, 2, 0, 32'h1001_0008, 32'hDEAD_BEEF);
    chk("pin_sw_addr", 32'(m_addr), 32'd2);
    chk("pin_sw_we", 32'(m_we), 32'hF);
    chk("pin_sw_wd", m_wd, 32'hDEAD_BEEF);

    do_req(1, 0, 0, 32'h1001_0011, 32'h0000_005A);
    chk("pin_sb_we", 32'(m_we), 32'h2);
    chk("pin_sb_wd", m_wd, 32'h5A5A_5A5A);
    do_req(0, 2, 0, 32'h1001_0010, 32'd0);
    chk("pin_lw_sb", m_rd, 32'h005A_0000);

    do_req(1, 2, 0, 32'h1001_0000, 32'h80FF_7F01);
    do_req(0, 0, 0, 32'h1001_0001, 32'd0);
    chk("pin_lb1", m_rd, 32'hFFFF_FFFF);
    do_req(0, 0, 1, 32'h1001_0001, 32'd0);
    chk("pin_lbu1", m_rd, 32'h0000_00FF);
    do_req(0, 1, 0, 32'h1001_0000, 32'd0);
    chk("pin_lh0", m_rd, 32'hFFFF_80FF);
    do_req(0, 1, 1, 32'h1001_0002, 32'd0);
    chk("pin_lhu2", m_rd, 32'h0000_7F01);
    do_req(0, 0, 0, 32'h1001_0003, 32'd0);
    do_req(0, 2, 0, 32'h1001_0008, 32'd0);
    chk("pin_lw_beef", m_rd, 32'hDEAD_BEEF);

    do_req(0, 2, 0, 32'h1000_FFFC, 32'd0);
    chk("pin_err_low", 32'(m_err), 32'd1);
    do_req(0, 2, 0, 32'h1001_2000, 32'd0);
    chk("pin_err_high", 32'(m_err), 32'd1);
    do_req(1, 2, 0, 32'h1001_2000, 32'h1234_5678);
    do_req(0, 3, 0, 32'h1001_0000, 32'd0);
    chk("pin_err_size", 32'(m_err), 32'd1);
    do_req(1, 2, 0, 32'h1001_1FFC, 32'hCAFE_F00D);
    chk("pin_last_addr", 32'(m_addr), 32'd2047);
    do_req(0, 2, 0, 32'h1001_1FFC, 32'd0);
    chk("pin_last_rd", m_rd, 32'hCAFE_F00D);

    do_req(1, 1, 0, 32'h1001_0022, 32'h0000_BEEF);
    chk("pin_sh_we", 32'(m_we), 32'hC);
    do_req(0, 2, 0, 32'h1001_0020, 32'd0);
    chk("pin_lw_sh", m_rd, 32'h0000_BEEF);
    do_req(1, 1, 0, 32'h1001_0021, 32'h0000_A5C3);
    do_req(0, 2, 0, 32'h1001_0020, 32'd0);

    do_req(1, 2, 0, 32'h1001_0004, 32'h1122_3344);
    do_req(0, 2, 0, 32'h1001_0006, 32'd0);
`ifdef ALIGN_CHECK_EN
    chk("pin_misalign", 32'(m_err), 32'd1);
`else
    chk("pin_misalign", m_rd, 32'h1122_3344);
`endif

    // Reset while the load is waiting on memory data.
    @(negedge clk);
    chk_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h1001_0004; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_issue", 32'(mem_en), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, mem_en, rsp_valid}, 32'd0);
    end
    chk_en = 1'b1;
    do_req(0, 2, 0, 32'h1001_0008, 32'd0);
    chk("pin_after_rst", m_rd, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    chk("pending_issue", 32'(iq.size()), 32'd0);
    chk("pending_resp", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
